// File: rtl/ptp_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : ptp_rx_capture
// Purpose  : Captures one Avalon-ST receive frame into a 256x32 frame RAM.
//            Payload goes to words 1..255, then a descriptor goes to word 0:
//            {truncated, 21'b0, byte_len[9:0]}. The buffer is then held until
//            the consumer acknowledges it.
// Ports    : clock, reset       - single clock, async active-high reset
//            in_data/in_valid/in_sop/in_eop/in_empty/in_ready
//                               - Avalon-ST sink (big-endian, 32-bit)
//            ram_address/ram_data/ram_wren/ram_byteena
//                               - registered frame RAM write port
//            frame_valid/frame_ack - buffer handshake to the consumer
//            frame_count        - descriptors written, wraps at 0xFFFF
// Revision : 1.0 - initial release
// ============================================================================
module ptp_rx_capture (
  input  logic        clock,
  input  logic        reset,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  input  logic        in_sop,
  input  logic        in_eop,
  input  logic [1:0]  in_empty,
  output logic        in_ready,
  output logic [7:0]  ram_address,
  output logic [31:0] ram_data,
  output logic        ram_wren,
  output logic [3:0]  ram_byteena,
  output logic        frame_valid,
  input  logic        frame_ack,
  output logic [15:0] frame_count
);

  localparam logic [2:0] S_IDLE    = 3'd0;
  localparam logic [2:0] S_CAPTURE = 3'd1;
  localparam logic [2:0] S_DROP    = 3'd2;
  localparam logic [2:0] S_DESC    = 3'd3;
  localparam logic [2:0] S_HOLD    = 3'd4;

  localparam logic [7:0] MAX_WORDS = 8'd255;

  logic [2:0]  state;
  logic [2:0]  state_next;
  logic [7:0]  word_count;
  logic        truncated;
  logic [1:0]  last_empty;

  logic        accept;
  logic [3:0]  beat_be;
  logic [1:0]  beat_empty;
  logic [9:0]  byte_len;

  logic        wr_en;
  logic [7:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_be;
  logic [7:0]  wc_next;
  logic        trunc_next;
  logic [1:0]  empty_next;
  logic        count_inc;
  logic        ready_next;

  assign accept     = in_valid & in_ready;
  // Unused bytes sit in the low-order lanes, so shift ones out from bit 0.
  assign beat_be    = in_eop ? (4'hF << in_empty) : 4'hF;
  assign beat_empty = in_eop ? in_empty : 2'd0;
  // A truncated frame lost its real eop, so the full word count is reported.
  assign byte_len   = {word_count, 2'b00} - {8'd0, (truncated ? 2'd0 : last_empty)};

  // --------------------------------------------------------------------------
  // State register
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // --------------------------------------------------------------------------
  // Next-state logic
  // --------------------------------------------------------------------------
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE: begin
        if (accept && in_sop) begin
          state_next = in_eop ? S_DESC : S_CAPTURE;
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          if (in_sop) begin
            state_next = in_eop ? S_DESC : S_CAPTURE;
          end else if (word_count == MAX_WORDS) begin
            // No room left: an eop here still closes the frame, as truncated.
            state_next = in_eop ? S_DESC : S_DROP;
          end else if (in_eop) begin
            state_next = S_DESC;
          end
        end
      end
      S_DROP: begin
        if (accept && in_eop) begin
          state_next = S_DESC;
        end
      end
      S_DESC: begin
        state_next = S_HOLD;
      end
      S_HOLD: begin
        // An ack only counts once the consumer has actually seen frame_valid.
        if (frame_ack && frame_valid) begin
          state_next = S_IDLE;
        end
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Output / datapath decode
  // --------------------------------------------------------------------------
  always_comb begin
    wr_en      = 1'b0;
    wr_addr    = 8'd0;
    wr_data    = in_data;
    wr_be      = 4'hF;
    wc_next    = word_count;
    trunc_next = truncated;
    empty_next = last_empty;
    count_inc  = 1'b0;
    case (state)
      S_IDLE: begin
        if (accept && in_sop) begin
          wr_en      = 1'b1;
          wr_addr    = 8'd1;
          wr_be      = beat_be;
          wc_next    = 8'd1;
          trunc_next = 1'b0;
          empty_next = beat_empty;
        end
      end
      S_CAPTURE: begin
        if (accept) begin
          if (in_sop) begin
            wr_en      = 1'b1;
            wr_addr    = 8'd1;
            wr_be      = beat_be;
            wc_next    = 8'd1;
            trunc_next = 1'b0;
            empty_next = beat_empty;
          end else if (word_count == MAX_WORDS) begin
            trunc_next = 1'b1;
          end else begin
            wr_en      = 1'b1;
            wr_addr    = word_count + 8'd1;
            wr_be      = beat_be;
            wc_next    = word_count + 8'd1;
            empty_next = beat_empty;
          end
        end
      end
      S_DESC: begin
        wr_en     = 1'b1;
        wr_addr   = 8'd0;
        wr_data   = {truncated, 21'd0, byte_len};
        wr_be     = 4'hF;
        count_inc = 1'b1;
      end
      default: begin
      end
    endcase
  end

  assign ready_next = (state_next == S_IDLE) || (state_next == S_CAPTURE) ||
                      (state_next == S_DROP);

  // --------------------------------------------------------------------------
  // Registered outputs and frame context
  // --------------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      word_count  <= 8'd0;
      truncated   <= 1'b0;
      last_empty  <= 2'd0;
      in_ready    <= 1'b0;
      ram_wren    <= 1'b0;
      ram_address <= 8'd0;
      ram_data    <= 32'd0;
      ram_byteena <= 4'd0;
      frame_valid <= 1'b0;
      frame_count <= 16'd0;
    end else begin
      word_count  <= wc_next;
      truncated   <= trunc_next;
      last_empty  <= empty_next;
      // Registered from the next state so the sink stalls on the very edge
      // that ends the frame, and only opens on the first edge after reset.
      in_ready    <= ready_next;
      ram_wren    <= wr_en;
      ram_address <= wr_addr;
      ram_data    <= wr_data;
      ram_byteena <= wr_be;
      // The descriptor lands during the first HOLD cycle; valid follows it.
      frame_valid <= (state == S_HOLD) && !(frame_ack && frame_valid);
      frame_count <= frame_count + {15'd0, count_inc};
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_ptp_rx_capture.sv
`default_nettype none
// ============================================================================
// Module   : tb_ptp_rx_capture
// Purpose  : Directed self-checking bench for ptp_rx_capture. A negedge
//            monitor records every RAM write into a shadow memory; each frame
//            result is compared with hand-computed values.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ptp_rx_capture;

  logic        clock;
  logic        reset;
  logic [31:0] in_data;
  logic        in_valid;
  logic        in_sop;
  logic        in_eop;
  logic [1:0]  in_empty;
  logic        in_ready;
  logic [7:0]  ram_address;
  logic [31:0] ram_data;
  logic        ram_wren;
  logic [3:0]  ram_byteena;
  logic        frame_valid;
  logic        frame_ack;
  logic [15:0] frame_count;

  int errors = 0;
  int checks = 0;

  logic [31:0] mem [0:255];
  logic [3:0]  be_mem [0:255];
  int          wr_count = 0;

  ptp_rx_capture dut (
    .clock       (clock),
    .reset       (reset),
    .in_data     (in_data),
    .in_valid    (in_valid),
    .in_sop      (in_sop),
    .in_eop      (in_eop),
    .in_empty    (in_empty),
    .in_ready    (in_ready),
    .ram_address (ram_address),
    .ram_data    (ram_data),
    .ram_wren    (ram_wren),
    .ram_byteena (ram_byteena),
    .frame_valid (frame_valid),
    .frame_ack   (frame_ack),
    .frame_count (frame_count)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(negedge clock) begin
    if (ram_wren) begin
      mem[ram_address]    = ram_data;
      be_mem[ram_address] = ram_byteena;
      wr_count            = wr_count + 1;
    end
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic clear_log();
    for (int i = 0; i < 256; i++) begin
      mem[i]    = 32'h0;
      be_mem[i] = 4'h0;
    end
    wr_count = 0;
  endtask

  task automatic send_beat(input logic [31:0] d, input logic s, input logic e,
                           input logic [1:0] emp);
    int guard;
    @(negedge clock);
    in_data  = d;
    in_valid = 1'b1;
    in_sop   = s;
    in_eop   = e;
    in_empty = emp;
    guard    = 0;
    while (!in_ready && guard < 100) begin
      @(negedge clock);
      guard++;
    end
    if (guard >= 100) check("ready_timeout", {31'd0, in_ready}, 32'd1);
    @(posedge clock);
  endtask

  task automatic go_idle();
    @(negedge clock);
    in_valid = 1'b0;
    in_sop   = 1'b0;
    in_eop   = 1'b0;
    in_empty = 2'd0;
  endtask

  task automatic wait_fv();
    int guard;
    guard = 0;
    while (!frame_valid && guard < 2000) begin
      @(negedge clock);
      guard++;
    end
    if (!frame_valid) check("fv_timeout", {31'd0, frame_valid}, 32'd1);
  endtask

  task automatic ack();
    @(negedge clock);
    frame_ack = 1'b1;
    @(negedge clock);
    frame_ack = 1'b0;
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_ready"}, {31'd0, in_ready}, 32'd0);
    check({tag, "_wren"},  {31'd0, ram_wren}, 32'd0);
    check({tag, "_addr"},  {24'd0, ram_address}, 32'd0);
    check({tag, "_data"},  ram_data, 32'd0);
    check({tag, "_be"},    {28'd0, ram_byteena}, 32'd0);
    check({tag, "_fv"},    {31'd0, frame_valid}, 32'd0);
    check({tag, "_fc"},    {16'd0, frame_count}, 32'd0);
  endtask

  initial begin
    int rdy_seen;
    int wc_snap;

    reset     = 1'b1;
    in_data   = 32'h0;
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    in_empty  = 2'd0;
    frame_ack = 1'b0;
    clear_log();

    // Reset state
    repeat (3) @(negedge clock);
    check_all_zero("rst");
    reset = 1'b0;
    @(negedge clock);
    check("rst_release_ready", {31'd0, in_ready}, 32'd1);

    // 3-beat frame, last beat empty=1
    clear_log();
    send_beat(32'h11223344, 1'b1, 1'b0, 2'd0);
    send_beat(32'h55667788, 1'b0, 1'b0, 2'd0);
    send_beat(32'hAABBCCDD, 1'b0, 1'b1, 2'd1);
    go_idle();
    wait_fv();
    check("a_w1", mem[1], 32'h11223344);
    check("a_w2", mem[2], 32'h55667788);
    check("a_w3", mem[3], 32'hAABBCCDD);
    check("a_be1", {28'd0, be_mem[1]}, 32'hF);
    check("a_be2", {28'd0, be_mem[2]}, 32'hF);
    check("a_be3", {28'd0, be_mem[3]}, 32'hE);
    check("a_desc", mem[0], 32'h0000000B);
    check("a_wrcnt", wr_count, 4);
    check("a_fc", {16'd0, frame_count}, 32'd1);

    // HOLD: back-pressure and ack
    wc_snap  = wr_count;
    rdy_seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clock);
      in_data  = 32'hDEADBEEF;
      in_valid = 1'b1;
      in_sop   = 1'b1;
      in_eop   = 1'b1;
      if (in_ready) rdy_seen++;
    end
    check("hold_ready", rdy_seen, 0);
    @(negedge clock);
    in_valid  = 1'b0;
    in_sop    = 1'b0;
    in_eop    = 1'b0;
    frame_ack = 1'b1;
    check("ack_cycle_ready", {31'd0, in_ready}, 32'd0);
    check("ack_cycle_fv", {31'd0, frame_valid}, 32'd1);
    @(negedge clock);
    frame_ack = 1'b0;
    check("post_ack_ready", {31'd0, in_ready}, 32'd1);
    check("post_ack_fv", {31'd0, frame_valid}, 32'd0);
    check("hold_no_writes", wr_count, wc_snap);

    // Single sop+eop beat with empty=3
    clear_log();
    send_beat(32'hA5A5A5A5, 1'b1, 1'b1, 2'd3);
    go_idle();
    wait_fv();
    check("b_w1", mem[1], 32'hA5A5A5A5);
    check("b_be1", {28'd0, be_mem[1]}, 32'h8);
    check("b_desc", mem[0], 32'h00000001);
    check("b_wrcnt", wr_count, 2);
    check("b_fc", {16'd0, frame_count}, 32'd2);
    ack();

    // 300-beat frame overflows after 255 payload words
    clear_log();
    for (int i = 1; i <= 300; i++) begin
      send_beat(i, (i == 1), (i == 300), 2'd2);
    end
    go_idle();
    wait_fv();
    check("c_w1", mem[1], 32'd1);
    check("c_w255", mem[255], 32'd255);
    check("c_be255", {28'd0, be_mem[255]}, 32'hF);
    check("c_desc", mem[0], 32'h800003FC);
    check("c_wrcnt", wr_count, 256);
    check("c_fc", {16'd0, frame_count}, 32'd3);
    ack();

    // Restart by sop mid-frame
    clear_log();
    send_beat(32'h01010101, 1'b1, 1'b0, 2'd0);
    send_beat(32'h02020202, 1'b0, 1'b0, 2'd0);
    send_beat(32'h0A0A0A0A, 1'b1, 1'b0, 2'd0);
    send_beat(32'h0B0B0B0B, 1'b0, 1'b1, 2'd2);
    go_idle();
    wait_fv();
    check("d_w1", mem[1], 32'h0A0A0A0A);
    check("d_w2", mem[2], 32'h0B0B0B0B);
    check("d_be2", {28'd0, be_mem[2]}, 32'hC);
    check("d_desc", mem[0], 32'h00000006);
    check("d_wrcnt", wr_count, 5);
    check("d_fc", {16'd0, frame_count}, 32'd4);
    ack();

    // Reset asserted on the second beat of a frame
    send_beat(32'h12345678, 1'b1, 1'b0, 2'd0);
    @(negedge clock);
    in_data  = 32'h9ABCDEF0;
    in_valid = 1'b1;
    in_sop   = 1'b0;
    #2 reset = 1'b1;
    #1 check_all_zero("mid_rst");
    in_valid = 1'b0;
    clear_log();
    repeat (3) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("e_ready", {31'd0, in_ready}, 32'd1);
    repeat (5) @(negedge clock);
    check("e_no_desc", wr_count, 0);
    check("e_fv", {31'd0, frame_valid}, 32'd0);
    send_beat(32'hCAFEBABE, 1'b1, 1'b0, 2'd0);
    send_beat(32'h01020304, 1'b0, 1'b1, 2'd0);
    go_idle();
    wait_fv();
    check("e_w1", mem[1], 32'hCAFEBABE);
    check("e_w2", mem[2], 32'h01020304);
    check("e_be2", {28'd0, be_mem[2]}, 32'hF);
    check("e_desc", mem[0], 32'h00000008);
    check("e_fc", {16'd0, frame_count}, 32'd1);
    ack();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/ptp_rx_capture.md
PTP_RX_CAPTURE -- requirements
Module: ptp_rx_capture

Interface
REQ-001 clock  input  1  single clock for all logic; shared with the downstream 256x32 frame RAM.
REQ-002 reset  input  1  asynchronous, active-high; clears all state.
REQ-003 in_data  input  32  Avalon-ST receive data; big-endian, first byte in bits [31:24].
REQ-004 in_valid  input  1  beat valid.
REQ-005 in_sop / in_eop  input  1 each  start and end of frame.
REQ-006 in_empty  input  2  count of unused low-order bytes on the eop beat; ignored on other beats.
REQ-007 in_ready  output  1  sink ready; a beat is accepted when in_valid and in_ready are both 1.
REQ-008 ram_address  output  8  RAM word address.
REQ-009 ram_data  output  32  RAM write data.
REQ-010 ram_wren  output  1  RAM write enable.
REQ-011 ram_byteena  output  4  RAM byte enables; bit 3 maps to data[31:24].
REQ-012 frame_valid  output  1  a complete frame and its descriptor are in RAM.
REQ-013 frame_ack  input  1  consumer releases the buffer.
REQ-014 frame_count  output  16  number of descriptors written; wraps at 0xFFFF.

Function
REQ-015 States: IDLE, CAPTURE, DROP, DESC, HOLD.
REQ-016 RAM layout: word 0 holds the descriptor; payload starts at word 1; 255 payload words maximum.
REQ-017 All ram_* outputs registered: a beat accepted in cycle N is written (ram_wren=1) in cycle N+1.
REQ-018 in_ready=1 in IDLE, CAPTURE and DROP; in_ready=0 in DESC, in HOLD and during reset.
REQ-019 IDLE: accepted beat without sop is discarded with no RAM write; accepted sop beat is written to address 1 with word count 1; next state is CAPTURE, or DESC if eop is also set.
REQ-020 CAPTURE: each accepted beat is written to address word_count+1, and word_count increments.
REQ-021 Byte enables: 4'hF on non-eop beats; on the eop beat, in_empty 0/1/2/3 gives 4'hF/4'hE/4'hC/4'h8.
REQ-022 An eop beat accepted in CAPTURE is written, then the state goes to DESC.
REQ-023 An sop beat accepted in CAPTURE restarts the frame: it is written to address 1, word_count=1, and the truncated flag is cleared.
REQ-024 Overflow: an accepted non-eop beat with word_count=255 is not written; truncated is set and the state goes to DROP.
REQ-025 DROP: accepted beats are discarded with no RAM writes; an accepted eop beat goes to DESC, and its in_empty is not used.
REQ-026 byte_len[9:0] = word_count*4 - in_empty of the last written eop beat; when truncated, byte_len = word_count*4.
REQ-027 DESC (exactly one cycle): writes address 0, data = {truncated, 21'b0, byte_len}, byteena 4'hF; frame_count increments; next state is HOLD.
REQ-028 HOLD: frame_valid=1 starting the cycle after the descriptor write; frame_ack=1 returns to IDLE with frame_valid=0 on the next cycle.
REQ-029 frame_ack is ignored outside HOLD.
REQ-030 ram_wren=0 whenever no write is required; ram_address and ram_data are don't-care when ram_wren=0.
REQ-031 ram_wren=1 in at most one cycle per accepted beat, plus one descriptor write per frame.

Reset
REQ-032 While reset=1: state=IDLE; word_count=0; truncated=0; in_ready=0; ram_wren=0; ram_address=0; ram_data=0; ram_byteena=0; frame_valid=0; frame_count=0.
REQ-033 Reset asserted mid-frame or in HOLD abandons the frame; no descriptor is written.
REQ-034 After reset deasserts, in_ready=1 from the first clock edge.

Verification
REQ-035 3-beat frame 0x11223344, 0x55667788, 0xAABBCCDD (eop, empty=1) -> writes at addresses 1/2/3, byteena F/F/E; descriptor 0x0000000B at address 0; frame_valid=1; frame_count=1.
REQ-036 Single beat with sop+eop, empty=3 -> address 1 written with byteena 8; descriptor 0x00000001.
REQ-037 300-beat frame -> 255 payload writes (addresses 1..255); beats 256..300 discarded; descriptor 0x800003FC.
REQ-038 In HOLD, hold in_valid=1 for 10 cycles, then pulse frame_ack -> in_ready=0 until one cycle after the ack; no RAM writes during HOLD.
REQ-039 sop after 2 beats of a frame, with no eop in between -> new frame restarts at address 1; final descriptor reflects only the new frame.
REQ-040 Reset asserted on the 2nd beat of a frame -> all outputs 0 asynchronously; no descriptor written; next frame captures normally with frame_count=1.
